// File: rtl/writeback_arbiter_if.sv
// Bundle of the two writeback sources, the allocation port, the busy scoreboard
// and the register-file write port. The arbiter binds the slave modport.
interface writeback_arbiter_if #(
  parameter int N = 32,
  parameter int n = 32
);
  localparam int M = $clog2(N);

  // A source transfer happens on a rising edge where valid and ready are both
  // high; ready never depends combinationally on valid.
  logic         alu_valid;
  logic         alu_ready;
  logic [M-1:0] alu_addr;
  logic [n-1:0] alu_data;

  logic         mem_valid;
  logic         mem_ready;
  logic [M-1:0] mem_addr;
  logic [n-1:0] mem_data;

  logic         alloc_valid;
  logic [M-1:0] alloc_addr;

  logic [N-1:0] busy;

  logic         write_enable;
  logic [M-1:0] write_addr;
  logic [n-1:0] data_in;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output mem_valid, mem_addr, mem_data,
    output alloc_valid, alloc_addr,
    input  alu_ready, mem_ready, busy,
    input  write_enable, write_addr, data_in
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  mem_valid, mem_addr, mem_data,
    input  alloc_valid, alloc_addr,
    output alu_ready, mem_ready, busy,
    output write_enable, write_addr, data_in
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges ALU and load results into one register-file write port, one write per
// cycle, round-robin under contention, and tracks pending writes per register.

module wb_queue #(
  parameter int AW    = 5,
  parameter int DW    = 32,
  parameter int DEPTH = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [AW-1:0] push_addr,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic          ready,
  output logic          not_empty,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0] addr_mem [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign ready     = (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];

  // Storage is not cleared on reset: entries are unreachable once count is 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        addr_mem[wr_ptr] <= push_addr;
        data_mem[wr_ptr] <= push_data;
        wr_ptr           <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

module writeback_arbiter #(
  parameter int N     = 32,
  parameter int n     = 32,
  parameter int DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst,
  writeback_arbiter_if.slave  bus
);
  localparam int M = $clog2(N);

  logic         alu_push, mem_push;
  logic         alu_pop, mem_pop;
  logic         alu_ready, mem_ready;
  logic         alu_ne, mem_ne;
  logic [M-1:0] alu_head_addr, mem_head_addr;
  logic [n-1:0] alu_head_data, mem_head_data;
  logic         last_grant;
  logic         grant_mem;
  logic         write_enable;
  logic [M-1:0] write_addr;
  logic [n-1:0] data_in;
  logic [N-1:0] busy_q;
  logic [N-1:0] busy_next;

  // Writes to x0 complete the handshake but are dropped before the queue.
  assign alu_push = bus.alu_valid && alu_ready && (bus.alu_addr != '0);
  assign mem_push = bus.mem_valid && mem_ready && (bus.mem_addr != '0);

  wb_queue #(.AW(M), .DW(n), .DEPTH(DEPTH)) u_alu_q (
    .clk       (clk),
    .rst       (rst),
    .push      (alu_push),
    .push_addr (bus.alu_addr),
    .push_data (bus.alu_data),
    .pop       (alu_pop),
    .ready     (alu_ready),
    .not_empty (alu_ne),
    .head_addr (alu_head_addr),
    .head_data (alu_head_data)
  );

  wb_queue #(.AW(M), .DW(n), .DEPTH(DEPTH)) u_mem_q (
    .clk       (clk),
    .rst       (rst),
    .push      (mem_push),
    .push_addr (bus.mem_addr),
    .push_data (bus.mem_data),
    .pop       (mem_pop),
    .ready     (mem_ready),
    .not_empty (mem_ne),
    .head_addr (mem_head_addr),
    .head_data (mem_head_data)
  );

  // last_grant: 0 = ALU granted last, so a tie goes to the load queue.
  always_comb begin
    grant_mem    = mem_ne && (!alu_ne || !last_grant);
    mem_pop      = grant_mem;
    alu_pop      = alu_ne && !grant_mem;
    write_enable = alu_ne || mem_ne;
    write_addr   = '0;
    data_in      = '0;
    if (mem_pop) begin
      write_addr = mem_head_addr;
      data_in    = mem_head_data;
    end else if (alu_pop) begin
      write_addr = alu_head_addr;
      data_in    = alu_head_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= 1'b0;
    end else if (alu_pop || mem_pop) begin
      last_grant <= mem_pop;
    end
  end

  // Set after clear so a same-cycle alloc beats the retiring write.
  always_comb begin
    busy_next = busy_q;
    if (write_enable) begin
      busy_next[write_addr] = 1'b0;
    end
    if (bus.alloc_valid && (bus.alloc_addr != '0)) begin
      busy_next[bus.alloc_addr] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_next;
    end
  end

  assign bus.alu_ready    = alu_ready;
  assign bus.mem_ready    = mem_ready;
  assign bus.busy         = busy_q;
  assign bus.write_enable = write_enable;
  assign bus.write_addr   = write_addr;
  assign bus.data_in      = data_in;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Bench for writeback_arbiter: scenario tasks drive the sources, a negedge
// monitor pops the expected-write queue whenever the write port fires.
module tb_writeback_arbiter;
  localparam int N     = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam int M     = $clog2(N);
  localparam int W     = M + DW;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  writeback_arbiter_if #(.N(N), .n(DW)) bus ();

  writeback_arbiter #(.N(N), .n(DW), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int           vectors     = 0;
  int           miscompares = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] mon_exp;
  bit           mon_en      = 1'b0;

  // Write-port monitor
  always @(negedge clk) begin
    if (mon_en) begin
      vectors++;
      if (bus.write_enable === 1'b1) begin
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL wr_unexpected: got addr=%0d data=%h, expected no write",
                   bus.write_addr, bus.data_in);
        end else begin
          mon_exp = exp_q.pop_front();
          if ({bus.write_addr, bus.data_in} !== mon_exp) begin
            miscompares++;
            $display("FAIL wr_data: got addr=%0d data=%h, expected addr=%0d data=%h",
                     bus.write_addr, bus.data_in, mon_exp[W-1:DW], mon_exp[DW-1:0]);
          end
        end
      end else if (bus.write_enable !== 1'b0 || bus.write_addr !== '0 || bus.data_in !== '0) begin
        miscompares++;
        $display("FAIL wr_idle: got we=%b addr=%0d data=%h, expected 0/0/0",
                 bus.write_enable, bus.write_addr, bus.data_in);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_valid   = 1'b0;
    bus.alu_addr    = '0;
    bus.alu_data    = '0;
    bus.mem_valid   = 1'b0;
    bus.mem_addr    = '0;
    bus.mem_data    = '0;
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
  endtask

  task automatic send_alu(input logic [M-1:0] a, input logic [DW-1:0] d, output int stalls);
    bit hs = 1'b0;
    int guard = 0;
    stalls = 0;
    bus.alu_valid = 1'b1;
    bus.alu_addr  = a;
    bus.alu_data  = d;
    while (!hs && guard < 50) begin
      hs = bus.alu_ready;
      if (!hs) stalls++;
      tick();
      guard++;
    end
    bus.alu_valid = 1'b0;
    vectors++;
    if (!hs) begin
      miscompares++;
      $display("FAIL alu_handshake: got no ready in 50 cycles, expected acceptance of addr=%0d", a);
    end
  endtask

  task automatic send_mem(input logic [M-1:0] a, input logic [DW-1:0] d, output int stalls);
    bit hs = 1'b0;
    int guard = 0;
    stalls = 0;
    bus.mem_valid = 1'b1;
    bus.mem_addr  = a;
    bus.mem_data  = d;
    while (!hs && guard < 50) begin
      hs = bus.mem_ready;
      if (!hs) stalls++;
      tick();
      guard++;
    end
    bus.mem_valid = 1'b0;
    vectors++;
    if (!hs) begin
      miscompares++;
      $display("FAIL mem_handshake: got no ready in 50 cycles, expected acceptance of addr=%0d", a);
    end
  endtask

  task automatic wait_drain();
    int g = 0;
    while (exp_q.size() != 0 && g < 100) begin
      tick();
      g++;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vectors++;
    if ({bus.write_enable, bus.write_addr, bus.data_in} !== '0) begin
      miscompares++;
      $display("FAIL reset_write: got we=%b addr=%0d data=%h, expected 0",
               bus.write_enable, bus.write_addr, bus.data_in);
    end
    vectors++;
    if (bus.busy !== '0) begin
      miscompares++;
      $display("FAIL reset_busy: got %h, expected 0", bus.busy);
    end
    vectors++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got alu=%b mem=%b, expected 1/1", bus.alu_ready, bus.mem_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_single();
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd5;
    tick();
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    vectors++;
    if (bus.busy[5] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_busy_set: got %b, expected 1", bus.busy[5]);
    end
    exp_q.push_back({5'd5, 32'hDEADBEEF});
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd5;
    bus.alu_data  = 32'hDEADBEEF;
    tick();
    bus.alu_valid = 1'b0;
    vectors++;
    if ({bus.write_enable, bus.write_addr, bus.data_in} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin
      miscompares++;
      $display("FAIL single_latency: got we=%b addr=%0d data=%h, expected 1/5/deadbeef",
               bus.write_enable, bus.write_addr, bus.data_in);
    end
    tick();
    vectors++;
    if (bus.busy[5] !== 1'b0 || bus.write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL single_clear: got busy5=%b we=%b, expected 0/0", bus.busy[5], bus.write_enable);
    end
  endtask

  task automatic test_contention();
    logic [M-1:0] alu_a [3] = '{5'd1, 5'd2, 5'd3};
    logic [M-1:0] mem_a [3] = '{5'd9, 5'd10, 5'd11};
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back({mem_a[i], 32'hA000_0000 + 32'(mem_a[i])});
      exp_q.push_back({alu_a[i], 32'hB000_0000 + 32'(alu_a[i])});
    end
    fork
      begin
        int s;
        for (int i = 0; i < 3; i++) send_alu(alu_a[i], 32'hB000_0000 + 32'(alu_a[i]), s);
      end
      begin
        int s;
        for (int i = 0; i < 3; i++) send_mem(mem_a[i], 32'hA000_0000 + 32'(mem_a[i]), s);
      end
    join
    wait_drain();
  endtask

  task automatic test_back_to_back();
    int alu_stalls = 0;
    int mem_stalls = 0;
    logic [M-1:0] order [8] = '{5'd12, 5'd20, 5'd13, 5'd21, 5'd14, 5'd22, 5'd15, 5'd23};
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({order[i], 32'(order[i]) * 32'h0101_0101 + 32'(i)});
    end
    fork
      begin
        int s;
        for (int i = 0; i < 4; i++) begin
          send_alu(order[2*i+1], 32'(order[2*i+1]) * 32'h0101_0101 + 32'(2*i+1), s);
          alu_stalls += s;
        end
      end
      begin
        int s;
        for (int i = 0; i < 4; i++) begin
          send_mem(order[2*i], 32'(order[2*i]) * 32'h0101_0101 + 32'(2*i), s);
          mem_stalls += s;
        end
      end
    join
    vectors++;
    if (mem_stalls !== 1) begin
      miscompares++;
      $display("FAIL backpressure_mem: got %0d stall cycles, expected 1", mem_stalls);
    end
    vectors++;
    if (alu_stalls !== 2) begin
      miscompares++;
      $display("FAIL backpressure_alu: got %0d stall cycles, expected 2", alu_stalls);
    end
    wait_drain();
  endtask

  task automatic test_x0_filter();
    logic [N-1:0] busy_snap;
    busy_snap = bus.busy;
    vectors++;
    if (bus.alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL x0_ready: got %b, expected 1", bus.alu_ready);
    end
    bus.alu_valid = 1'b1;
    bus.alu_addr  = '0;
    bus.alu_data  = 32'h0000_1234;
    tick();
    bus.alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (bus.write_enable !== 1'b0 || bus.busy !== busy_snap || bus.alu_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL x0_filter: got we=%b busy=%h rdy=%b, expected 0/%h/1",
                 bus.write_enable, bus.busy, bus.alu_ready, busy_snap);
      end
      tick();
    end
  endtask

  task automatic test_alloc_collision();
    exp_q.push_back({5'd7, 32'h0000_0077});
    bus.alu_valid = 1'b1;
    bus.alu_addr  = 5'd7;
    bus.alu_data  = 32'h0000_0077;
    tick();
    bus.alu_valid   = 1'b0;
    bus.alloc_valid = 1'b1;
    bus.alloc_addr  = 5'd7;
    vectors++;
    if (bus.write_enable !== 1'b1 || bus.write_addr !== 5'd7) begin
      miscompares++;
      $display("FAIL collide_write: got we=%b addr=%0d, expected 1/7", bus.write_enable, bus.write_addr);
    end
    tick();
    bus.alloc_valid = 1'b0;
    bus.alloc_addr  = '0;
    vectors++;
    if (bus.busy[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL collide_busy: got %b, expected 1", bus.busy[7]);
    end
    exp_q.push_back({5'd7, 32'h0000_0078});
    bus.alu_valid = 1'b1;
    bus.alu_data  = 32'h0000_0078;
    bus.alu_addr  = 5'd7;
    tick();
    bus.alu_valid = 1'b0;
    tick();
    vectors++;
    if (bus.busy[7] !== 1'b0) begin
      miscompares++;
      $display("FAIL collide_clear: got %b, expected 0", bus.busy[7]);
    end
  endtask

  task automatic test_reset_midop();
    exp_q.push_back({5'd24, 32'hC000_0001});
    exp_q.push_back({5'd17, 32'hD000_0001});
    bus.alu_valid   = 1'b1;  bus.alu_addr = 5'd17;  bus.alu_data = 32'hD000_0001;
    bus.mem_valid   = 1'b1;  bus.mem_addr = 5'd24;  bus.mem_data = 32'hC000_0001;
    bus.alloc_valid = 1'b1;  bus.alloc_addr = 5'd3;
    tick();
    bus.alloc_valid = 1'b0;
    bus.alu_addr = 5'd18;  bus.alu_data = 32'hD000_0002;
    bus.mem_addr = 5'd25;  bus.mem_data = 32'hC000_0002;
    vectors++;
    if (bus.busy[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_alloc: got %b, expected 1", bus.busy[3]);
    end
    tick();
    bus.alu_addr = 5'd19;  bus.alu_data = 32'hD000_0003;
    bus.mem_addr = 5'd26;  bus.mem_data = 32'hC000_0003;
    bus.alloc_valid = 1'b1;  bus.alloc_addr = 5'd6;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_inputs();
    vectors++;
    if (bus.write_enable !== 1'b0 || bus.busy !== '0) begin
      miscompares++;
      $display("FAIL midop_reset: got we=%b busy=%h, expected 0/0", bus.write_enable, bus.busy);
    end
    vectors++;
    if (bus.alu_ready !== 1'b1 || bus.mem_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midop_ready: got alu=%b mem=%b, expected 1/1", bus.alu_ready, bus.mem_ready);
    end
    repeat (5) tick();
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL midop_pending: got %0d writes never seen, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_back_to_back();
    test_x0_filter();
    test_alloc_collision();
    test_reset_midop();
    mon_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
WRITEBACK_ARBITER -- requirements
Module: writeback_arbiter

Interface
REQ-001 Parameter N, default 32, number of architectural registers.
REQ-002 Parameter n, default 32, register data width in bits.
REQ-003 Parameter DEPTH, default 2, entries per source queue; legal values are 2 and 4.
REQ-004 Localparam M, $clog2(N), register address width.
REQ-005 clk  input  1  single clock; all state updates on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 alu_valid  input  1  ALU result offered.
REQ-008 alu_ready  output  1  ALU queue can accept a result this cycle.
REQ-009 alu_addr  input  M  ALU destination register.
REQ-010 alu_data  input  n  ALU result data.
REQ-011 mem_valid  input  1  load result offered.
REQ-012 mem_ready  output  1  load queue can accept a result this cycle.
REQ-013 mem_addr  input  M  load destination register.
REQ-014 mem_data  input  n  load result data.
REQ-015 alloc_valid  input  1  issue stage claims a destination register.
REQ-016 alloc_addr  input  M  claimed destination register.
REQ-017 busy  output  N  per-register pending-write scoreboard.
REQ-018 write_enable  output  1  register-file write strobe.
REQ-019 write_addr  output  M  register-file write address.
REQ-020 data_in  output  n  register-file write data.

Function
REQ-021 A source handshake occurs on a rising edge where valid and ready are both high; the arbiter SHALL push {addr, data} into that source's FIFO queue.
REQ-022 The arbiter SHALL drive ready = (queue occupancy < DEPTH) from registered state only, with no combinational path from valid.
REQ-023 The arbiter SHALL accept a handshake whose addr is 0, consume it, and never enqueue it.
REQ-024 The arbiter SHALL drive write_enable high whenever at least one queue is non-empty.
REQ-025 The arbiter SHALL drive write_addr and data_in from the head of the granted queue, and SHALL drive them to 0 when write_enable is low.
REQ-026 The arbiter SHALL pop the granted head on the same rising edge that the register file samples the write; this gives exactly one write per cycle.
REQ-027 Latency: a result handshaken at edge k into an empty, uncontended queue SHALL appear on the write port during the cycle after edge k.
REQ-028 Grant with exactly one queue non-empty: that queue.
REQ-029 Grant with both queues non-empty: round-robin using a 1-bit last-grant register, granting the source not granted last; last-grant updates only on a pop.
REQ-030 The arbiter SHALL preserve FIFO order within each source.
REQ-031 A push and a pop on the same queue in the same cycle SHALL leave occupancy unchanged; this is legal even when the queue is full only if ready was high.
REQ-032 Occupancy counters and read/write pointers SHALL wrap modulo DEPTH.
REQ-033 busy bit r (r != 0) SHALL set on an edge where alloc_valid is high and alloc_addr = r.
REQ-034 busy bit r SHALL clear on an edge where a write to r is popped.
REQ-035 Simultaneous alloc and write-pop to the same r in one cycle: busy[r] SHALL end set (the new producer wins).
REQ-036 busy[0] SHALL be constant 0; alloc_addr = 0 SHALL be ignored.
REQ-037 A write-pop to r with busy[r] already clear SHALL leave busy[r] clear; this case is not an error.

Reset
REQ-038 While rst is high at an edge, the arbiter SHALL empty both queues, zero the pointers and counters, clear busy to all zeros, and clear last-grant to 0 (0 = ALU granted last).
REQ-039 During and after reset: write_enable = 0, write_addr = 0, data_in = 0, and alu_ready = mem_ready = 1 from the first cycle after the reset edge.
REQ-040 Handshakes and allocs at a reset edge SHALL be discarded; reset mid-operation SHALL drop all queued results.

Verification
REQ-041 Single ALU result: alloc x5, then alu {5, 0xDEADBEEF} at edge k -> busy[5] = 1 after alloc; write_enable = 1, write_addr = 5, data_in = 0xDEADBEEF in the cycle after edge k; busy[5] = 0 after the next edge.
REQ-042 Contention: both sources push continuously, with ALU addrs 1,2,3 and mem addrs 9,10,11 -> the write port alternates, starting mem 9, then 1, 10, 2, 11, 3; one write per cycle, no loss.
REQ-043 Backpressure with DEPTH = 2: mem pushes 3 consecutive results while ALU holds the grant -> mem_ready drops after 2 accepted; the third is accepted only after a pop; order is preserved.
REQ-044 x0 filter: alu {0, 0x1234} -> the handshake completes; write_enable stays 0 and busy is unchanged.
REQ-045 Same-cycle alloc and writeback to x7 -> busy[7] = 1 after the edge; a later write to x7 clears it.
REQ-046 Reset with 2 entries queued in each source -> write_enable = 0 and busy = 0 the next cycle, both ready signals = 1, and no stale write appears afterwards.
